// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// It watches the instruction sitting in ID and the redirect outcome from EX.
// From these it drives the PC/IF-ID hold, the IF-ID flush, the ID/EX bubble
// and the registered EX operand forwarding selects.
// A small shadow pipeline (EX, MEM) records the destination register, the
// write enable and the load flag of the instructions ahead of ID.
//
// Ports
//   clock, reset      system clock; asynchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_rs1/id_rs2     ID source registers, with id_use_rs1/id_use_rs2 flags
//   id_rd, id_reg_en  ID destination and write enable
//   id_memtoreg       ID instruction is a load
//   ex_redirect       EX resolved a taken branch/jump this cycle
//   ext_stall         external freeze of the whole pipeline
//   stall_pc          hold PC and IF/ID
//   flush_ifid        replace IF/ID with NOP
//   bubble_ex         load NOP into ID/EX
//   fwd_a, fwd_b      EX operand selects: 0 regfile, 1 EX/MEM, 2 MEM/WB
//   busy_state        0 RUN, 1 LD_STALL, 2 FLUSH
//   stall_count       cycles spent in LD_STALL (saturating)
//   flush_count       accepted redirects (saturating)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_en,
  input  logic             id_memtoreg,
  input  logic             ex_redirect,
  input  logic             ext_stall,
  output logic             stall_pc,
  output logic             flush_ifid,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       busy_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] flush_cnt;
  logic [1:0] flush_cnt_next;

  // Shadow pipeline. The WB stage needs no shadow: an instruction in MEM
  // while its consumer is in ID is exactly the MEM/WB source one cycle later.
  logic [4:0] ex_rd;
  logic       ex_wen;
  logic       ex_load;
  logic [4:0] mem_rd;
  logic       mem_wen;

  logic       load_use;
  logic       advance;
  logic       stall_inc;
  logic       flush_inc;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A source matches a producer only if it is really read, really written
  // and not x0.
  function automatic logic reg_match(input logic [4:0] rs, input logic use_rs,
                                     input logic [4:0] rd, input logic wen);
    return use_rs && wen && (rd != 5'd0) && (rs == rd);
  endfunction

  // Forward select for one operand; the nearer producer (EX) wins.
  function automatic logic [1:0] fwd_pick(input logic [4:0] rs, input logic use_rs,
                                          input logic [4:0] e_rd, input logic e_wen,
                                          input logic e_load,
                                          input logic [4:0] m_rd, input logic m_wen);
    logic [1:0] sel;
    if (reg_match(rs, use_rs, e_rd, e_wen) && !e_load) begin
      sel = 2'd1;
    end else if (reg_match(rs, use_rs, m_rd, m_wen)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  assign busy_state = state;

  // Load-use detection against the load currently in EX.
  always_comb begin
    load_use = id_valid && ex_load &&
               (reg_match(id_rs1, id_use_rs1, ex_rd, ex_wen) ||
                reg_match(id_rs2, id_use_rs2, ex_rd, ex_wen));
  end

  // Next-state and control outputs; ext_stall freezes, redirect beats load-use.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    stall_pc       = 1'b0;
    flush_ifid     = 1'b0;
    bubble_ex      = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (reset) begin
      state_next     = RUN;
      flush_cnt_next = 2'd0;
    end else if (ext_stall) begin
      stall_pc = 1'b1;
    end else if (ex_redirect) begin
      flush_ifid = 1'b1;
      bubble_ex  = 1'b1;
      flush_inc  = 1'b1;
      stall_inc  = (state == LD_STALL);
      // The redirect cycle is itself the first squashed slot.
      if (FLUSH_CYCLES > 1) begin
        state_next     = FLUSH;
        flush_cnt_next = 2'(FLUSH_CYCLES - 1);
      end else begin
        state_next     = RUN;
        flush_cnt_next = 2'd0;
      end
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            stall_pc   = 1'b1;
            bubble_ex  = 1'b1;
            state_next = LD_STALL;
          end else begin
            state_next = RUN;
          end
        end
        LD_STALL: begin
          stall_inc  = 1'b1;
          state_next = RUN;
        end
        FLUSH: begin
          if (flush_cnt != 2'd0) begin
            flush_ifid     = 1'b1;
            bubble_ex      = 1'b1;
            flush_cnt_next = flush_cnt - 2'd1;
            if (flush_cnt == 2'd1) begin
              state_next = RUN;
            end else begin
              state_next = FLUSH;
            end
          end else begin
            state_next = RUN;
          end
        end
        default: begin
          state_next     = RUN;
          flush_cnt_next = 2'd0;
        end
      endcase
    end
  end

  // Forward selects for the instruction leaving ID; zero when nothing advances.
  always_comb begin
    advance = id_valid && !ext_stall && !bubble_ex;
    if (advance) begin
      fwd_a_next = fwd_pick(id_rs1, id_use_rs1, ex_rd, ex_wen, ex_load, mem_rd, mem_wen);
      fwd_b_next = fwd_pick(id_rs2, id_use_rs2, ex_rd, ex_wen, ex_load, mem_rd, mem_wen);
    end else begin
      fwd_a_next = 2'd0;
      fwd_b_next = 2'd0;
    end
  end

  // FSM, shadow pipeline, forward selects and saturating counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      flush_cnt   <= 2'd0;
      ex_rd       <= 5'd0;
      ex_wen      <= 1'b0;
      ex_load     <= 1'b0;
      mem_rd      <= 5'd0;
      mem_wen     <= 1'b0;
      fwd_a       <= 2'd0;
      fwd_b       <= 2'd0;
      stall_count <= {CNT_W{1'b0}};
      flush_count <= {CNT_W{1'b0}};
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      if (!ext_stall) begin
        mem_rd  <= ex_rd;
        mem_wen <= ex_wen;
        if (advance) begin
          ex_rd   <= id_rd;
          ex_wen  <= id_reg_en;
          ex_load <= id_memtoreg;
        end else begin
          ex_rd   <= 5'd0;
          ex_wen  <= 1'b0;
          ex_load <= 1'b0;
        end
        fwd_a <= fwd_a_next;
        fwd_b <= fwd_b_next;
      end
      if (stall_inc && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
      if (flush_inc && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, CNT_W=16).
// The stimulus process drives one cycle of inputs and pushes the hand-computed
// output vector for that cycle. The monitor pops and compares it on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_en;
  logic        id_memtoreg;
  logic        ex_redirect;
  logic        ext_stall;
  logic        stall_pc;
  logic        flush_ifid;
  logic        bubble_ex;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [1:0]  busy_state;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_en(id_reg_en), .id_memtoreg(id_memtoreg),
    .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .stall_pc(stall_pc), .flush_ifid(flush_ifid), .bubble_ex(bubble_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy_state(busy_state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // {stall_pc, flush_ifid, bubble_ex, fwd_a, fwd_b, busy_state, stall_count, flush_count}
  logic [40:0] exp_q[$];
  string       name_q[$];
  int          compared   = 0;
  int          mismatched = 0;

  logic [40:0] act;
  logic [40:0] e_v;
  string       n_s;
  assign act = {stall_pc, flush_ifid, bubble_ex, fwd_a, fwd_b, busy_state, stall_count, flush_count};

  // Monitor: compare each cycle that has a pending expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      n_s = name_q.pop_front();
      compared++;
      if (act !== e_v) begin
        mismatched++;
        $display("FAIL %s: got spc=%0b fl=%0b bub=%0b fa=%0d fb=%0d st=%0d sc=%0d fc=%0d, expected spc=%0b fl=%0b bub=%0b fa=%0d fb=%0d st=%0d sc=%0d fc=%0d",
                 n_s, act[40], act[39], act[38], act[37:36], act[35:34], act[33:32], act[31:16], act[15:0],
                 e_v[40], e_v[39], e_v[38], e_v[37:36], e_v[35:34], e_v[33:32], e_v[31:16], e_v[15:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic ins(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic u1, input logic u2,
                     input logic wen, input logic ld);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_reg_en = wen; id_memtoreg = ld;
  endtask

  task automatic nop();
    ins(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ins(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);
    ins(1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic ctl(input logic redir, input logic xs);
    ex_redirect = redir; ext_stall = xs;
  endtask

  task automatic expect_out(input string name, input logic spc, input logic fl, input logic bub,
                            input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st,
                            input logic [15:0] sc, input logic [15:0] fc);
    exp_q.push_back({spc, fl, bub, fa, fb, st, sc, fc});
    name_q.push_back(name);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    ctl(1'b0, 1'b0);
    cyc(); expect_out("reset",        1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);

    // Back-to-back ALU dependency
    cyc(); reset = 1'b0; alu(5'd5, 5'd1, 5'd2);
           expect_out("add_x5",       1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    cyc(); alu(5'd6, 5'd5, 5'd7);
           expect_out("sub_in_id",    1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    cyc(); nop();
           expect_out("fwd_dist1",    1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 16'd0, 16'd0);

    // Distance-2 dependency
    cyc(); alu(5'd5, 5'd1, 5'd2);
           expect_out("add_x5_b",     1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    cyc(); nop();
           expect_out("gap_nop",      1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    cyc(); alu(5'd8, 5'd5, 5'd5);
           expect_out("or_in_id",     1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    cyc(); nop();
           expect_out("fwd_dist2",    1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd0, 16'd0, 16'd0);

    // Load-use
    cyc(); lw(5'd3, 5'd1);
           expect_out("lw_x3",        1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    cyc(); alu(5'd4, 5'd3, 5'd1);
           expect_out("load_use",     1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    cyc(); alu(5'd4, 5'd3, 5'd1);
           expect_out("ld_stall",     1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 16'd0, 16'd0);
    cyc(); nop();
           expect_out("fwd_after_ld", 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 16'd1, 16'd0);

    // x0 destination never hazards or forwards
    cyc(); lw(5'd0, 5'd1);
           expect_out("lw_x0",        1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd1, 16'd0);
    cyc(); alu(5'd1, 5'd0, 5'd0);
           expect_out("x0_no_stall",  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd1, 16'd0);
    cyc(); nop();
           expect_out("x0_no_fwd",    1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd1, 16'd0);
    cyc(); nop();
           expect_out("drain",        1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd1, 16'd0);

    // Taken branch, then a redirect arriving during FLUSH
    cyc(); ctl(1'b1, 1'b0);
           expect_out("redirect1",    1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 16'd1, 16'd0);
    cyc(); ctl(1'b0, 1'b0);
           expect_out("flush1",       1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd2, 16'd1, 16'd1);
    cyc(); expect_out("flush1_done",  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd1, 16'd1);
    cyc(); ctl(1'b1, 1'b0);
           expect_out("redirect2",    1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 16'd1, 16'd1);
    cyc(); expect_out("redir_in_fl",  1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd2, 16'd1, 16'd2);
    cyc(); ctl(1'b0, 1'b0);
           expect_out("flush_restart",1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd2, 16'd1, 16'd3);
    cyc(); expect_out("flush2_done",  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd1, 16'd3);

    // Redirect and load-use in the same cycle
    cyc(); lw(5'd3, 5'd1);
           expect_out("lw_x3_b",      1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd1, 16'd3);
    cyc(); alu(5'd4, 5'd3, 5'd1); ctl(1'b1, 1'b0);
           expect_out("redir_vs_ld",  1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 16'd1, 16'd3);
    cyc(); nop(); ctl(1'b0, 1'b0);
           expect_out("flush3",       1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd2, 16'd1, 16'd4);
    cyc(); expect_out("no_ld_stall",  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd1, 16'd4);

    // ext_stall held 3 cycles inside LD_STALL (redirect ignored meanwhile)
    cyc(); lw(5'd3, 5'd1);
           expect_out("lw_x3_c",      1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd1, 16'd4);
    cyc(); alu(5'd4, 5'd3, 5'd1);
           expect_out("load_use2",    1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 16'd1, 16'd4);
    cyc(); ctl(1'b0, 1'b1);
           expect_out("xs_1",         1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 16'd1, 16'd4);
    cyc(); ctl(1'b1, 1'b1);
           expect_out("xs_2_redir",   1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 16'd1, 16'd4);
    cyc(); ctl(1'b0, 1'b1);
           expect_out("xs_3",         1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 16'd1, 16'd4);
    cyc(); ctl(1'b0, 1'b0);
           expect_out("xs_release",   1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 16'd1, 16'd4);
    cyc(); nop();
           expect_out("fwd_after_xs", 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 16'd2, 16'd4);

    // Reset pulse while in FLUSH
    cyc(); ctl(1'b1, 1'b0);
           expect_out("redirect4",    1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 16'd2, 16'd4);
    cyc(); expect_out("flush4",       1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd2, 16'd2, 16'd5);
    cyc(); reset = 1'b1;
           expect_out("reset_in_fl",  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    cyc(); reset = 1'b0; ctl(1'b0, 1'b0);
           expect_out("post_reset",   1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);

    // Shadow pipeline works again after reset
    cyc(); alu(5'd5, 5'd1, 5'd2);
           expect_out("add_x5_c",     1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    cyc(); alu(5'd6, 5'd7, 5'd5);
           expect_out("sub_in_id_c",  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    cyc(); nop();
           expect_out("fwd_b_dist1",  1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 16'd0, 16'd0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() > 0) begin
        @(negedge clock);
      end
    end
    #1;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It sits beside the decode controller. It consumes decoded register fields and control flags for the instruction in ID, plus the branch/jump resolution from EX. It drives PC/IF-ID stall, IF-ID flush and EX bubble insertion, and registered forwarding selects for the EX operand muxes. It keeps its own shadow pipeline of destination info plus stall/flush performance counters.

Parameters:
FLUSH_CYCLES, 2, number of younger instructions squashed on a taken branch/jump (1..3)
CNT_W, 16, width of the performance counters

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high
id_valid  input  1  ID holds a real instruction (0 = NOP/bubble)
id_rs1  input  5  source register 1 of ID instruction
id_rs2  input  5  source register 2 of ID instruction
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_rd  input  5  destination of ID instruction
id_reg_en  input  1  ID instruction writes rd (REG_EN)
id_memtoreg  input  1  ID instruction is a load (MEMTOREG)
ex_redirect  input  1  EX resolved taken branch, JAL or JALR this cycle
ext_stall  input  1  external freeze (memory wait); holds whole pipeline
stall_pc  output  1  hold PC and IF/ID register
flush_ifid  output  1  replace IF/ID contents with NOP
bubble_ex  output  1  load NOP into ID/EX instead of ID instruction
fwd_a  output  2  EX operand A select: 0 regfile, 1 EX/MEM result, 2 MEM/WB result
fwd_b  output  2  EX operand B select, same encoding
busy_state  output  2  FSM state: 0 RUN, 1 LD_STALL, 2 FLUSH
stall_count  output  CNT_W  cycles spent in LD_STALL
flush_count  output  CNT_W  taken redirects accepted

Behaviour:
- Reset (async, immediate): all outputs 0; state RUN; shadow regs (ex/mem/wb rd, wen, load) cleared; flush counter 0.
- Shadow pipeline: per stage rd[4:0], wen, load. On each clock without ext_stall, shift ID->EX->MEM->WB. ID info enters EX only when it advances (not stalled, not bubbled, id_valid=1); otherwise EX gets rd=0, wen=0, load=0.
- Register x0 never creates a hazard or a forward; a match requires rs==rd, rd!=0, wen=1, use_rsN=1.
- Load-use (combinational in RUN): id_valid and a used rs matches EX-shadow rd with load=1 -> stall_pc=1, bubble_ex=1 this cycle; next state LD_STALL.
- LD_STALL: lasts exactly one cycle, with stall_pc=0 and bubble_ex=0. The load is now in MEM, so the dependant forwards from MEM/WB (select 2). Returns to RUN. stall_count increments once per LD_STALL cycle, saturating at all-ones.
- Forwarding: computed when an ID instruction advances and registered into fwd_a/fwd_b, so the selects are valid while it sits in EX.
  - Match with current EX shadow (non-load) -> 1.
  - Else match with MEM shadow -> 2.
  - Else 0. The nearer stage wins.
  - On a bubble, fwd_a/fwd_b become 0.
- Redirect: ex_redirect=1 in any state has priority over load-use. That cycle: flush_ifid=1, bubble_ex=1, stall_pc=0. State becomes FLUSH with counter=FLUSH_CYCLES-1; flush_count increments (saturating).
- FLUSH: flush_ifid=1 and bubble_ex=1 while counter>0, counter decrements. At 0, return to RUN with outputs deasserted. A new ex_redirect during FLUSH reloads the counter and increments flush_count.
- ext_stall=1 overrides everything:
  - stall_pc=1, flush_ifid=0, bubble_ex=0.
  - FSM, counters, shadow regs and fwd selects all hold.
  - A pending redirect/load-use is evaluated after release; ex_redirect is ignored while ext_stall=1.
- Reset mid-FLUSH or mid-LD_STALL: immediate return to RUN, no residual flush or bubble.

Test Plan:
- Back-to-back ALU dependency: ADD x5 then SUB x6,x5,x7 -> no stall; SUB in EX sees fwd_a=1, fwd_b=0.
- Distance-2 dependency: ADD x5, NOP, OR x8,x5,x5 -> fwd_a=2, fwd_b=2; load-use LW x3 then ADD x4,x3,x1 -> one cycle stall_pc=1/bubble_ex=1, then fwd_a=2, stall_count=1.
- x0 destination: LW x0 then ADD x1,x0,x0 -> no stall, fwd_a=fwd_b=0.
- Taken BEQ with FLUSH_CYCLES=2 -> flush_ifid high 2 consecutive cycles, busy_state 2 for 1 cycle then 0, flush_count=1; second redirect during FLUSH -> window restarts, flush_count=2.
- Redirect and load-use same cycle -> flush wins, no LD_STALL entered, stall_count unchanged.
- ext_stall held 3 cycles mid-LD_STALL, then reset pulse during FLUSH -> state/counters frozen for 3 cycles; after reset all outputs 0 and busy_state=0 immediately.
